// File: rtl/if_pc_gen.sv
// Fetch-address generator: sequential PC stepping, jump/branch redirects, stall freeze,
// and buffering of a redirect that arrives while the pipeline is stalled.
module if_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fc_jump_flag_i,
    input  logic [31:0] fc_jump_pc_i,
    input  logic        fc_stall_flag_i,
    output logic [31:0] pc_o,
    output logic        pc_req_o,
    output logic        pc_redirect_o,
    output logic        pend_valid_o,
    output logic        jump_misalign_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_req;
    logic        r_redirect;
    logic        r_pend_valid;
    logic        r_misalign;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_pend_pc_nxt;
    logic        w_req_nxt;
    logic        w_redirect_nxt;
    logic        w_pend_valid_nxt;
    logic        w_misalign_nxt;
    logic [31:0] w_tgt_aligned;
    logic        w_tgt_misaligned;

    assign w_tgt_aligned    = {fc_jump_pc_i[31:2], 2'b00};
    assign w_tgt_misaligned = |fc_jump_pc_i[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_pend_pc    <= 32'h0000_0000;
            r_req        <= 1'b0;
            r_redirect   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_req        <= w_req_nxt;
            r_redirect   <= w_redirect_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_misalign   <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT: w_state_nxt = RUN;
            RUN:  if (fc_jump_flag_i && fc_stall_flag_i) w_state_nxt = HOLD;
            HOLD: if (!fc_stall_flag_i) w_state_nxt = RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

    // A jump seen while stalled is parked in r_pend_pc; the newest one wins until release.
    always_comb begin
        w_pc_nxt         = r_pc;
        w_pend_pc_nxt    = r_pend_pc;
        w_req_nxt        = r_req;
        w_redirect_nxt   = r_redirect;
        w_pend_valid_nxt = r_pend_valid;
        w_misalign_nxt   = 1'b0;
        case (r_state)
            BOOT: w_req_nxt = 1'b1;
            RUN: begin
                if (fc_jump_flag_i && !fc_stall_flag_i) begin
                    w_pc_nxt       = w_tgt_aligned;
                    w_redirect_nxt = 1'b1;
                    w_misalign_nxt = w_tgt_misaligned;
                end else if (fc_jump_flag_i) begin
                    w_pend_pc_nxt    = w_tgt_aligned;
                    w_pend_valid_nxt = 1'b1;
                    w_misalign_nxt   = w_tgt_misaligned;
                end else if (!fc_stall_flag_i) begin
                    w_pc_nxt       = r_pc + PC_STEP;
                    w_redirect_nxt = 1'b0;
                end
            end
            HOLD: begin
                if (fc_stall_flag_i) begin
                    if (fc_jump_flag_i) begin
                        w_pend_pc_nxt  = w_tgt_aligned;
                        w_misalign_nxt = w_tgt_misaligned;
                    end
                end else begin
                    w_pc_nxt         = fc_jump_flag_i ? w_tgt_aligned : r_pend_pc;
                    w_misalign_nxt   = fc_jump_flag_i && w_tgt_misaligned;
                    w_pend_valid_nxt = 1'b0;
                    w_redirect_nxt   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign pc_o            = r_pc;
    assign pc_req_o        = r_req;
    assign pc_redirect_o   = r_redirect;
    assign pend_valid_o    = r_pend_valid;
    assign jump_misalign_o = r_misalign;

endmodule

// File: tb/tb_if_pc_gen.sv
// Self-checking bench for if_pc_gen: directed scenarios plus random jump/stall traffic,
// all checked against a queue-based behavioural model of the fetch PC.
module tb_if_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jumpFlag = 1'b0;
    logic [31:0] jumpPc = 32'h0;
    logic        stallFlag = 1'b0;
    logic [31:0] pcOut;
    logic        pcReq;
    logic        pcRedirect;
    logic        pendValid;
    logic        jumpMisalign;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pending redirect kept as a queue of at most one target.
    bit          mStarted;
    bit          mReq;
    bit          mRedirect;
    bit          mMisalign;
    logic [31:0] mPc;
    logic [31:0] pendQ[$];

    if_pc_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fc_jump_flag_i  (jumpFlag),
        .fc_jump_pc_i    (jumpPc),
        .fc_stall_flag_i (stallFlag),
        .pc_o            (pcOut),
        .pc_req_o        (pcReq),
        .pc_redirect_o   (pcRedirect),
        .pend_valid_o    (pendValid),
        .jump_misalign_o (jumpMisalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("pc", pcOut, mPc);
        checkOutput("req", {31'b0, pcReq}, {31'b0, mReq});
        checkOutput("redirect", {31'b0, pcRedirect}, {31'b0, mRedirect});
        checkOutput("pend", {31'b0, pendValid}, {31'b0, (pendQ.size() != 0)});
        checkOutput("misalign", {31'b0, jumpMisalign}, {31'b0, mMisalign});
    endtask

    task automatic modelReset();
        mStarted  = 1'b0;
        mReq      = 1'b0;
        mRedirect = 1'b0;
        mMisalign = 1'b0;
        mPc       = 32'h0;
        pendQ.delete();
    endtask

    task automatic modelEdge(input bit jump, input logic [31:0] tgt, input bit stall);
        logic [31:0] aligned;
        aligned   = tgt & 32'hFFFF_FFFC;
        mMisalign = 1'b0;
        if (!mStarted) begin
            mStarted = 1'b1;
            mReq     = 1'b1;
        end else if (pendQ.size() == 0) begin
            if (jump) mMisalign = (tgt % 4) != 0;
            if (jump && !stall) begin
                mPc       = aligned;
                mRedirect = 1'b1;
            end else if (jump) begin
                pendQ.push_back(aligned);
            end else if (!stall) begin
                mPc       = mPc + 32'd4;
                mRedirect = 1'b0;
            end
        end else begin
            if (jump) mMisalign = (tgt % 4) != 0;
            if (stall) begin
                if (jump) begin
                    pendQ.delete();
                    pendQ.push_back(aligned);
                end
            end else begin
                mPc = jump ? aligned : pendQ[0];
                pendQ.delete();
                mRedirect = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare against the model.
    task automatic applyStimulus(input bit jump, input logic [31:0] tgt, input bit stall);
        jumpFlag  = jump;
        jumpPc    = tgt;
        stallFlag = stall;
        @(posedge clk);
        modelEdge(jump, tgt, stall);
        #1;
        checkAll();
    endtask

    task automatic doReset();
        jumpFlag  = 1'b0;
        stallFlag = 1'b0;
        rst_n     = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        doReset();

        // Boot then sequential stepping
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("seq_0xC", pcOut, 32'h0000_000C);

        // Unstalled jump and follow-on step
        applyStimulus(1'b1, 32'h0000_0100, 1'b0);
        checkOutput("jump_0x100", pcOut, 32'h0000_0100);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Jump inside a three-cycle stall, released on the fourth edge
        applyStimulus(1'b1, 32'h0000_0200, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("buffered_0x200", pcOut, 32'h0000_0200);

        // Newest pending target wins; release coinciding with a jump takes the new jump
        applyStimulus(1'b1, 32'h0000_0300, 1'b1);
        applyStimulus(1'b1, 32'h0000_0400, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("newest_0x400", pcOut, 32'h0000_0400);
        applyStimulus(1'b1, 32'h0000_0600, 1'b1);
        applyStimulus(1'b1, 32'h0000_0500, 1'b0);
        checkOutput("release_jump_0x500", pcOut, 32'h0000_0500);

        // Misaligned target, then top-of-memory wrap
        applyStimulus(1'b1, 32'h0000_0203, 1'b0);
        checkOutput("misalign_pulse", {31'b0, jumpMisalign}, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("misalign_cleared", {31'b0, jumpMisalign}, 32'h0);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("wrap_zero", pcOut, 32'h0000_0000);

        // Asynchronous reset with a redirect pending
        applyStimulus(1'b1, 32'h0000_0800, 1'b1);
        checkOutput("pend_before_reset", {31'b0, pendValid}, 32'h1);
        #2;
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("post_reset_pc", pcOut, 32'h0000_0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(3) == 0), $urandom, ($urandom_range(2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
